// File: rtl/dtw_result_filter_if.sv
// Result-FIFO read port and AXI4-Stream master bundle for dtw_result_filter.
interface dtw_result_filter_if #(
  parameter int unsigned AXIS_WIDTH = 32
);
  logic                  res_fifo_rden;
  logic                  res_fifo_empty;
  logic [31:0]           res_fifo_data;
  logic [AXIS_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport master (
    output res_fifo_rden,
    input  res_fifo_empty,
    input  res_fifo_data,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tlast
  );

  modport slave (
    input  res_fifo_rden,
    output res_fifo_empty,
    output res_fifo_data,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tlast
  );
endinterface

// File: rtl/dtw_result_filter.sv
// Drains 3-word DTW result records and forwards those scoring at or below a
// threshold as 3-beat AXI4-Stream packets; the rest are dropped and counted.
module dtw_result_filter #(
  parameter int unsigned AXIS_WIDTH = 32,
  parameter int unsigned WIDTH      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               filter_en,
  input  logic [WIDTH-1:0]   thresh,
  dtw_result_filter_if.master bus,
  output logic               busy,
  output logic [31:0]        pass_count,
  output logic [31:0]        drop_count
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECIDE = 2'd1,
    SEND   = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                iss_q, iss_d;
  logic [IDX_W-1:0]                cap_q, cap_d;
  logic                            rd_vld_q, rd_vld_d;
  logic [2:0][AXIS_WIDTH-1:0]      rec_q, rec_d;
  logic [IDX_W-1:0]                beat_q, beat_d;
  logic                            tvalid_q, tvalid_d;
  logic [AXIS_WIDTH-1:0]           tdata_q, tdata_d;
  logic                            tlast_q, tlast_d;
  logic                            busy_q, busy_d;
  logic [CNT_W-1:0]                pass_q, pass_d;
  logic [CNT_W-1:0]                drop_q, drop_d;
  logic                            rden_c;
  logic                            pass_c;
  logic [IDX_W-1:0]                nxt_beat_c;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      iss_q    <= '0;
      cap_q    <= '0;
      rd_vld_q <= 1'b0;
      rec_q    <= '0;
      beat_q   <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      pass_q   <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      iss_q    <= iss_d;
      cap_q    <= cap_d;
      rd_vld_q <= rd_vld_d;
      rec_q    <= rec_d;
      beat_q   <= beat_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
      pass_q   <= pass_d;
      drop_q   <= drop_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    iss_d      = iss_q;
    cap_d      = cap_q;
    rec_d      = rec_q;
    beat_d     = beat_q;
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    tlast_d    = tlast_q;
    pass_d     = pass_q;
    drop_d     = drop_q;
    rden_c     = 1'b0;
    pass_c     = 1'b0;
    nxt_beat_c = beat_q + IDX_W'(1);

    unique case (state_q)
      FETCH: begin
        rden_c = rst_n && !bus.res_fifo_empty && (iss_q != IDX_W'(3));
        if (rden_c) iss_d = iss_q + IDX_W'(1);
        if (rd_vld_q) begin
          rec_d[cap_q] = bus.res_fifo_data;
          cap_d        = cap_q + IDX_W'(1);
          // Third word lands: record complete, counters rearm for the next one
          if (cap_q == IDX_W'(2)) begin
            state_d = DECIDE;
            iss_d   = '0;
            cap_d   = '0;
          end
        end
      end

      DECIDE: begin
        pass_c = !filter_en || (rec_q[2][WIDTH-1:0] <= thresh);
        if (pass_c) begin
          state_d  = SEND;
          beat_d   = '0;
          tvalid_d = 1'b1;
          tdata_d  = rec_q[0];
          tlast_d  = 1'b0;
        end else begin
          state_d = FETCH;
          if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
        end
      end

      SEND: begin
        if (tvalid_q && bus.m_axis_tready) begin
          if (beat_q == IDX_W'(2)) begin
            state_d  = FETCH;
            beat_d   = '0;
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tlast_d  = 1'b0;
            if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
          end else begin
            beat_d  = nxt_beat_c;
            tdata_d = rec_q[nxt_beat_c];
            tlast_d = (nxt_beat_c == IDX_W'(2));
          end
        end
      end

      default: state_d = FETCH;
    endcase

    rd_vld_d = rden_c;
    busy_d   = !((state_d == FETCH) && (iss_d == '0));
  end

  assign bus.res_fifo_rden = rden_c;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign busy              = busy_q;
  assign pass_count        = pass_q;
  assign drop_count        = drop_q;

endmodule
